ov7670_sccb_config_ctrl: RTL and testbench

Sequencer that powers up the OV7670 camera and loads its register set over SCCB (3-phase write) from an external table ROM. It sits between the board switches (resend request) and the camera control pins (sioc/siod/reset/pwdn) inside flappy_bird_logic. It runs automatically after reset and re-runs on a resend request.

---
 rtl/ov7670_sccb_config_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_ov7670_sccb_config_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_config_ctrl.sv
//-----------------------------------------------------------------------------
// ov7670_sccb_config_ctrl
//
// Powers up the OV7670 camera and then walks an external register table,
// writing each entry to the camera over SCCB as a 3-phase write:
// {DEV_ID, reg_addr, reg_data}. Runs once automatically after reset. A rising
// edge on the resend switch while idle in DONE replays the table. The camera
// power-up sequence is not repeated on a replay.
//
// Table entry encoding (rom_data):
//   16'hFFFF : end of table
//   16'hFFF0 : wait DLY_CYC cycles
//   other    : {reg_addr, reg_data}
//
// Ports:
//   sys_clk       system clock, all logic on the rising edge
//   sys_rst_n     asynchronous active-low reset
//   resend        asynchronous switch level; a rising edge in DONE replays
//   rom_addr      table index
//   rom_data      table entry, combinational from rom_addr
//   sioc          SCCB clock
//   siod_o        SCCB data drive value
//   siod_oe       1 = drive siod_o, 0 = release the pad (top-level tristate)
//   siod_i        SCCB data sampled from the pad
//   ov7670_reset  camera reset, active low
//   ov7670_pwdn   camera power-down, held 0
//   busy          sequence in progress
//   done          table completed; cleared on a replay
//   nack_err      sticky NACK flag
//
// Build option:
//   SCCB_ACK_CHECK_EN  when defined, siod_i is sampled in each 9th bit slot and
//                      a high value sets nack_err. When undefined, siod_i is
//                      ignored and nack_err is tied to 0.
//-----------------------------------------------------------------------------
module ov7670_sccb_config_ctrl #(
    parameter int         CLK_FREQ_HZ  = 50000000,
    parameter int         SCCB_FREQ_HZ = 100000,
    parameter int         PWR_WAIT_CYC = 1000000,
    parameter int         GAP_CYC      = 500,
    parameter int         DLY_CYC      = 500000,
    parameter logic [7:0] DEV_ID       = 8'h42
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        resend,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    input  logic        siod_i,
    output logic        ov7670_reset,
    output logic        ov7670_pwdn,
    output logic        busy,
    output logic        done,
    output logic        nack_err
);

    localparam int          QTR       = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam logic [31:0] QTR_LAST  = 32'(QTR - 1);
    localparam logic [31:0] PWR_LAST  = 32'(PWR_WAIT_CYC - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [31:0] DLY_LAST  = 32'(DLY_CYC - 1);

    typedef enum logic [3:0] {
        PWR_RST,
        PWR_SET,
        FETCH,
        START,
        BITS,
        STOP,
        GAP,
        DELAY,
        DONE
    } state_t;

    typedef struct packed {
        logic sioc;
        logic sda;
        logic oe;
        logic cam_rst;
        logic busy;
        logic done;
    } pins_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [1:0]  phase, phase_nx;
    logic [4:0]  slot, slot_nx;
    logic [26:0] tx_bits, tx_bits_nx;
    logic [7:0]  addr_nx;
    logic        rs_meta, rs_sync, rs_prev;
    logic        restart;
    logic        qtr_end;
    pins_t       pins_nx;

    // The 9th slot of each byte is the slave's acknowledge window.
    function automatic logic is_ack_slot(input logic [4:0] sl);
        return (sl == 5'd8) || (sl == 5'd17) || (sl == 5'd26);
    endfunction

    // Pin levels for a given position in the sequence. Decoded from the
    // next-state values and registered, so the pins are glitch-free yet
    // follow the state with no extra cycle of lag.
    function automatic pins_t decode_pins(input state_t st, input logic [1:0] ph,
                                          input logic [4:0] sl, input logic [26:0] bits);
        pins_t p;
        p.sioc    = 1'b1;
        p.sda     = 1'b1;
        p.oe      = 1'b0;
        p.cam_rst = 1'b1;
        p.busy    = 1'b1;
        p.done    = 1'b0;
        case (st)
            PWR_RST: p.cam_rst = 1'b0;
            START: begin
                p.oe   = 1'b1;
                p.sda  = 1'b0;
                p.sioc = (ph == 2'd0);
            end
            BITS: begin
                p.sioc = ph[1];
                if (!is_ack_slot(sl)) begin
                    p.oe  = 1'b1;
                    p.sda = bits[5'd26 - sl];
                end
            end
            STOP: begin
                if (ph == 2'd0) begin
                    p.sioc = 1'b0;
                    p.oe   = 1'b1;
                    p.sda  = 1'b0;
                end else if (ph == 2'd1) begin
                    p.oe   = 1'b1;
                    p.sda  = 1'b0;
                end
            end
            DONE: begin
                p.busy = 1'b0;
                p.done = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

    // Resend switch synchroniser and rising-edge detect.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rs_meta <= 1'b0;
            rs_sync <= 1'b0;
            rs_prev <= 1'b0;
        end else begin
            rs_meta <= resend;
            rs_sync <= rs_meta;
            rs_prev <= rs_sync;
        end
    end

    // A resend edge outside DONE is simply dropped.
    assign restart = (state == DONE) && rs_sync && !rs_prev;
    assign qtr_end = (cnt == QTR_LAST);

    // Next-state logic. The cycle counter restarts on every state entry and,
    // in START/BITS/STOP, on every quarter-period boundary.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 32'd1;
        phase_nx   = phase;
        slot_nx    = slot;
        tx_bits_nx = tx_bits;
        addr_nx    = rom_addr;
        case (state)
            PWR_RST: begin
                if (cnt == PWR_LAST) begin
                    state_nx = PWR_SET;
                    cnt_nx   = 32'd0;
                end
            end
            PWR_SET: begin
                if (cnt == PWR_LAST) begin
                    state_nx = FETCH;
                    cnt_nx   = 32'd0;
                end
            end
            FETCH: begin
                cnt_nx = 32'd0;
                if (rom_data == 16'hFFFF) begin
                    state_nx = DONE;
                end else if (rom_data == 16'hFFF0) begin
                    state_nx = DELAY;
                end else begin
                    // Ack slots carry a 1 so the released line reads high.
                    tx_bits_nx = {DEV_ID, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
                    state_nx   = START;
                    phase_nx   = 2'd0;
                end
            end
            START: begin
                if (qtr_end) begin
                    cnt_nx = 32'd0;
                    if (phase == 2'd1) begin
                        state_nx = BITS;
                        phase_nx = 2'd0;
                        slot_nx  = 5'd0;
                    end else begin
                        phase_nx = phase + 2'd1;
                    end
                end
            end
            BITS: begin
                if (qtr_end) begin
                    cnt_nx   = 32'd0;
                    phase_nx = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (slot == 5'd26) begin
                            state_nx = STOP;
                            slot_nx  = 5'd0;
                        end else begin
                            slot_nx = slot + 5'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (qtr_end) begin
                    cnt_nx = 32'd0;
                    if (phase == 2'd3) begin
                        state_nx = GAP;
                        phase_nx = 2'd0;
                    end else begin
                        phase_nx = phase + 2'd1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = FETCH;
                    cnt_nx   = 32'd0;
                    addr_nx  = rom_addr + 8'd1;
                end
            end
            DELAY: begin
                if (cnt == DLY_LAST) begin
                    state_nx = FETCH;
                    cnt_nx   = 32'd0;
                    addr_nx  = rom_addr + 8'd1;
                end
            end
            DONE: begin
                cnt_nx = cnt;
                if (restart) begin
                    state_nx = FETCH;
                    cnt_nx   = 32'd0;
                    addr_nx  = 8'd0;
                end
            end
            default: begin
                state_nx = PWR_RST;
                cnt_nx   = 32'd0;
            end
        endcase
    end

    assign pins_nx = decode_pins(state_nx, phase_nx, slot_nx, tx_bits_nx);

    // State, counters and registered pin outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= PWR_RST;
            cnt          <= 32'd0;
            phase        <= 2'd0;
            slot         <= 5'd0;
            tx_bits      <= 27'd0;
            rom_addr     <= 8'd0;
            sioc         <= 1'b1;
            siod_o       <= 1'b1;
            siod_oe      <= 1'b0;
            ov7670_reset <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            phase        <= phase_nx;
            slot         <= slot_nx;
            tx_bits      <= tx_bits_nx;
            rom_addr     <= addr_nx;
            sioc         <= pins_nx.sioc;
            siod_o       <= pins_nx.sda;
            siod_oe      <= pins_nx.oe;
            ov7670_reset <= pins_nx.cam_rst;
            busy         <= pins_nx.busy;
            done         <= pins_nx.done;
        end
    end

    assign ov7670_pwdn = 1'b0;

`ifdef SCCB_ACK_CHECK_EN
    logic ack_sample;
    logic nack_q, nack_nx;

    // Sample once, in the first cycle after sioc rises inside an ack slot.
    assign ack_sample = (state == BITS) && (phase == 2'd2) && (cnt == 32'd0) && is_ack_slot(slot);

    always_comb begin
        nack_nx = nack_q;
        if (restart) begin
            nack_nx = 1'b0;
        end else if (ack_sample && siod_i) begin
            nack_nx = 1'b1;
        end
    end

    // Sticky NACK flag; the sequence never aborts on it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            nack_q <= 1'b0;
        end else begin
            nack_q <= nack_nx;
        end
    end

    assign nack_err = nack_q;
`else
    logic unused_siod;
    assign unused_siod = siod_i;
    assign nack_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_sccb_config_ctrl.sv
//-----------------------------------------------------------------------------
// tb_ov7670_sccb_config_ctrl
//
// Directed bench for ov7670_sccb_config_ctrl with a tiny timing set
// (QTR = 2, PWR_WAIT_CYC = 10, GAP_CYC = 6, DLY_CYC = 50). A bus monitor
// decodes START/STOP conditions and bytes from the SCCB pins on every falling
// sys_clk edge and timestamps them against a free-running rising-edge count.
//-----------------------------------------------------------------------------
module tb_ov7670_sccb_config_ctrl;

    localparam int CLK_HZ  = 800;
    localparam int SCCB_HZ = 100;
    localparam int QTR     = CLK_HZ / (4 * SCCB_HZ);
    localparam int PWR     = 10;
    localparam int GAP     = 6;
    localparam int DLY     = 50;

`ifdef SCCB_ACK_CHECK_EN
    localparam int ACK_EN = 1;
`else
    localparam int ACK_EN = 0;
`endif

    logic        sys_clk;
    logic        sys_rst_n;
    logic        resend;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sioc;
    logic        siod_o;
    logic        siod_oe;
    logic        siod_i;
    logic        ov7670_reset;
    logic        ov7670_pwdn;
    logic        busy;
    logic        done;
    logic        nack_err;

    logic [15:0] rom [0:255];
    logic        nack_inject;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Bus monitor state
    int          nstart      = 0;
    int          nstop       = 0;
    int          bit_cnt     = 27;
    int          ack_oe_err  = 0;
    int          rst_rise_n  = 0;
    int          rst_rise_t  = 0;
    int          start_t [0:63];
    int          stop_t  [0:63];
    int          fall_t  [0:63];
    int          rise1_t [0:63];
    logic [7:0]  mon_bytes [$];

    ov7670_sccb_config_ctrl #(
        .CLK_FREQ_HZ (CLK_HZ),
        .SCCB_FREQ_HZ(SCCB_HZ),
        .PWR_WAIT_CYC(PWR),
        .GAP_CYC     (GAP),
        .DLY_CYC     (DLY),
        .DEV_ID      (8'h42)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .resend      (resend),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sioc        (sioc),
        .siod_o      (siod_o),
        .siod_oe     (siod_oe),
        .siod_i      (siod_i),
        .ov7670_reset(ov7670_reset),
        .ov7670_pwdn (ov7670_pwdn),
        .busy        (busy),
        .done        (done),
        .nack_err    (nack_err)
    );

    assign rom_data = rom[rom_addr];

    // Slave answers ACK (0) except when a NACK is injected into the second
    // acknowledge slot of a transaction (bit_cnt 17 before, 18 after its rise).
    assign siod_i = nack_inject && !siod_oe && (bit_cnt == 17 || bit_cnt == 18);

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
        end
    end

    // Bus monitor: line is the pad level with a pull-up when released.
    initial begin
        logic       line;
        logic       prev_line;
        logic       prev_sioc;
        logic       prev_rst;
        logic       fall_pend;
        logic [7:0] cur;
        int         idx;
        prev_line = 1'b1;
        prev_sioc = 1'b1;
        prev_rst  = 1'b0;
        fall_pend = 1'b0;
        cur       = 8'd0;
        forever begin
            @(negedge sys_clk);
            line = siod_oe ? siod_o : 1'b1;
            if (sys_rst_n) begin
                if (prev_sioc && sioc && prev_line && !line) begin
                    if (nstart < 64) start_t[nstart] = cyc;
                    nstart++;
                    bit_cnt   = 0;
                    fall_pend = 1'b1;
                end else if (prev_sioc && sioc && !prev_line && line) begin
                    if (nstop < 64) stop_t[nstop] = cyc;
                    nstop++;
                end
                if (prev_sioc && !sioc && fall_pend) begin
                    if (nstart > 0 && nstart <= 64) fall_t[nstart-1] = cyc;
                    fall_pend = 1'b0;
                end
                if (!prev_sioc && sioc && bit_cnt < 27) begin
                    bit_cnt++;
                    if (bit_cnt == 1 && nstart > 0 && nstart <= 64) rise1_t[nstart-1] = cyc;
                    idx = (bit_cnt - 1) % 9;
                    if (idx == 8) begin
                        if (siod_oe) ack_oe_err++;
                    end else begin
                        cur = {cur[6:0], line};
                        if (idx == 7) mon_bytes.push_back(cur);
                    end
                end
            end
            if (!prev_rst && ov7670_reset) begin
                rst_rise_n++;
                rst_rise_t = cyc;
            end
            prev_sioc = sioc;
            prev_line = line;
            prev_rst  = ov7670_reset;
        end
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst_n_val, input logic resend_val);
        sys_rst_n = rst_n_val;
        resend    = resend_val;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic waitDone(input int budget, input string tag);
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge sys_clk);
            #1;
        end
        checkOutput(tag, int'(done), 1);
    endtask

    task automatic waitStart(input int base, input int budget, input string tag);
        for (int i = 0; i < budget && nstart <= base; i++) @(negedge sys_clk);
        checkOutput(tag, int'(nstart > base), 1);
    endtask

    // 0: single write; 1: write, delay, write.
    task automatic loadTable(input int which);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        if (which == 1) begin
            rom[1] = 16'hFFF0;
            rom[2] = 16'h1101;
        end
    endtask

    initial begin
        int rel;
        int bs;
        int bst;
        int bb;
        int br;
        int k;

        nack_inject = 1'b0;
        applyStimulus(1'b0, 1'b0);
        loadTable(0);

        // Reset values
        waitCycles(3);
        checkOutput("rst_sioc", int'(sioc), 1);
        checkOutput("rst_siod_o", int'(siod_o), 1);
        checkOutput("rst_siod_oe", int'(siod_oe), 0);
        checkOutput("rst_cam_reset", int'(ov7670_reset), 0);
        checkOutput("rst_pwdn", int'(ov7670_pwdn), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_nack", int'(nack_err), 0);
        checkOutput("rst_rom_addr", int'(rom_addr), 0);

        // Power-up then a single write {42,12,80}
        @(negedge sys_clk);
        applyStimulus(1'b1, 1'b0);
        rel = cyc;
        waitCycles(1);
        checkOutput("busy_after_release", int'(busy), 1);
        checkOutput("cam_reset_low_pwr", int'(ov7670_reset), 0);
        waitDone(3000, "done_single");
        checkOutput("cam_reset_rise_cyc", rst_rise_t - rel, PWR);
        // PWR_RST and PWR_SET each PWR cycles, then one FETCH cycle.
        checkOutput("first_start_cyc", start_t[0] - rel, 2 * PWR + 1);
        checkOutput("start_sioc_fall", fall_t[0] - start_t[0], QTR);
        checkOutput("first_data_rise", rise1_t[0] - start_t[0], 4 * QTR);
        checkOutput("single_starts", nstart, 1);
        checkOutput("single_stops", nstop, 1);
        checkOutput("byte0_id", int'(mon_bytes[0]), 'h42);
        checkOutput("byte1_reg", int'(mon_bytes[1]), 'h12);
        checkOutput("byte2_val", int'(mon_bytes[2]), 'h80);
        checkOutput("ack_slots_released", ack_oe_err, 0);
        checkOutput("single_busy", int'(busy), 0);
        checkOutput("single_rom_addr", int'(rom_addr), 1);
        checkOutput("pwdn_low", int'(ov7670_pwdn), 0);

        // Async reset in the middle of BITS (slot 2, sioc low, siod driven)
        loadTable(1);
        @(negedge sys_clk);
        applyStimulus(1'b0, 1'b0);
        @(negedge sys_clk);
        applyStimulus(1'b1, 1'b0);
        bs = nstart;
        waitStart(bs, 500, "start_before_midrst");
        waitCycles(20);
        @(posedge sys_clk);
        #3;
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("midrst_sioc", int'(sioc), 1);
        checkOutput("midrst_siod_oe", int'(siod_oe), 0);
        checkOutput("midrst_cam_reset", int'(ov7670_reset), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge sys_clk);
        applyStimulus(1'b1, 1'b0);
        waitCycles(1);
        checkOutput("midrst_busy_after", int'(busy), 1);

        // Delay table, with a resend pulse during BITS that must be dropped
        bs  = nstart;
        bst = nstop;
        bb  = mon_bytes.size();
        waitStart(bs, 500, "start_delay_table");
        waitCycles(20);
        applyStimulus(1'b1, 1'b1);
        waitCycles(6);
        applyStimulus(1'b1, 1'b0);
        waitDone(3000, "done_delay_table");
        checkOutput("delay_starts", nstart - bs, 2);
        checkOutput("delay_b0", int'(mon_bytes[bb]), 'h42);
        checkOutput("delay_b1", int'(mon_bytes[bb+1]), 'h12);
        checkOutput("delay_b2", int'(mon_bytes[bb+2]), 'h80);
        checkOutput("delay_b3", int'(mon_bytes[bb+3]), 'h42);
        checkOutput("delay_b4", int'(mon_bytes[bb+4]), 'h11);
        checkOutput("delay_b5", int'(mon_bytes[bb+5]), 'h01);
        // STOP q2+q3, GAP, FETCH, DELAY, FETCH between STOP edge and next START
        checkOutput("delay_interval", start_t[bs+1] - stop_t[bst], 2 * QTR + GAP + DLY + 2);
        checkOutput("delay_rom_addr", int'(rom_addr), 3);
        checkOutput("delay_busy", int'(busy), 0);
        checkOutput("delay_ack_released", ack_oe_err, 0);
        waitCycles(20);
        checkOutput("resend_ignored_done", int'(done), 1);
        checkOutput("resend_ignored_starts", nstart - bs, 2);

        // Resend in DONE, with NACK injected into each second ack slot
        bs = nstart;
        bb = mon_bytes.size();
        br = rst_rise_n;
        nack_inject = 1'b1;
        applyStimulus(1'b1, 1'b1);
        k = 0;
        while (done && k < 3) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        checkOutput("resend_done_drop", int'(done), 0);
        checkOutput("resend_rom_addr", int'(rom_addr), 0);
        checkOutput("resend_busy", int'(busy), 1);
        applyStimulus(1'b1, 1'b0);
        waitDone(3000, "done_replay");
        nack_inject = 1'b0;
        checkOutput("replay_nack", int'(nack_err), ACK_EN);
        checkOutput("replay_starts", nstart - bs, 2);
        checkOutput("replay_b4", int'(mon_bytes[bb+4]), 'h11);
        checkOutput("replay_no_cam_toggle", rst_rise_n - br, 0);
        checkOutput("replay_cam_reset_high", int'(ov7670_reset), 1);

        // Second resend clears the sticky flag
        applyStimulus(1'b1, 1'b1);
        k = 0;
        while (done && k < 3) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        checkOutput("resend2_done_drop", int'(done), 0);
        checkOutput("resend2_nack_cleared", int'(nack_err), 0);
        applyStimulus(1'b1, 1'b0);
        waitDone(3000, "done_replay2");
        checkOutput("replay2_nack", int'(nack_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
